// File: rtl/cmp_stream.sv
// Pipelined magnitude comparator with a valid/ready stream interface and
// saturating per-outcome event counters.
module cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             equal,
  output logic             lower,
  output logic [WIDTH-1:0] diff,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);

  logic             valid_q, valid_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cgt_q, cgt_d;
  logic [CNT_W-1:0] ceq_q, ceq_d;
  logic [CNT_W-1:0] clt_q, clt_d;

  logic [WIDTH:0]   ext_a, ext_b;
  logic             cmp_gt, cmp_eq, accept;
  logic [WIDTH-1:0] abs_diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Unsigned operands zero-extend, so a signed compare on WIDTH+1 bits
  // serves both modes.
  always_comb begin
    ext_a  = {signed_mode & a[WIDTH-1], a};
    ext_b  = {signed_mode & b[WIDTH-1], b};
    cmp_gt = $signed(ext_a) > $signed(ext_b);
    cmp_eq = (ext_a == ext_b);
    // The exact difference always fits in WIDTH bits, so modular WIDTH-bit
    // subtraction equals the truncated extended difference.
    abs_diff = cmp_gt ? (a - b) : (b - a);
  end

  always_comb begin
    valid_d = valid_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    diff_d  = diff_q;
    cgt_d   = cgt_q;
    ceq_d   = ceq_q;
    clt_d   = clt_q;

    if (accept) begin
      valid_d = 1'b1;
      gt_d    = cmp_gt;
      eq_d    = cmp_eq;
      lt_d    = !cmp_gt && !cmp_eq;
      diff_d  = abs_diff;
      if (cmp_gt)      cgt_d = sat_inc(cgt_q);
      else if (cmp_eq) ceq_d = sat_inc(ceq_q);
      else             clt_d = sat_inc(clt_q);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      cgt_d = '0;
      ceq_d = '0;
      clt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      diff_q  <= '0;
      cgt_q   <= '0;
      ceq_q   <= '0;
      clt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      diff_q  <= diff_d;
      cgt_q   <= cgt_d;
      ceq_q   <= ceq_d;
      clt_q   <= clt_d;
    end
  end

  assign out_valid = valid_q;
  assign greater   = gt_q;
  assign equal     = eq_q;
  assign lower     = lt_q;
  assign diff      = diff_q;
  assign cnt_gt    = cgt_q;
  assign cnt_eq    = ceq_q;
  assign cnt_lt    = clt_q;

endmodule
